cpu_controller: RTL
===================

# cpu_controller

Moore-style sequencing FSM for the 16-bit CPU datapath. It sits beside the instruction decoder. It accepts an instruction from the fetch side via a `start`/`waiting` handshake and latches the decoded `opcode`/`ALU_op`. It then drives register-select, write-back and load-enable strobes over several cycles to execute MOV, ALU and HALT instructions, and it keeps a wrapping count of retired instructions.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request to execute the instruction currently in the IR. Sampled only in S_WAIT.
- `opcode`  in  3  decoder opcode (IR[15:13]). Sampled only with `start`.
- `ALU_op`  in  2  decoder ALU/op field (IR[12:11]). Sampled only with `start`.
- `waiting`  out  1  high only in S_WAIT; the controller is ready for `start`.
- `halted`  out  1  high only in S_HALT.
- `reg_sel`  out  2  to the decoder register mux: 10=Rn, 01=Rd, 00=Rm.
- `wb_sel`  out  2  write-back source: 00=ALU result C, 10=sximm8. Other codes are never driven.
- `w_en`  out  1  register file write enable.
- `en_A`, `en_B`, `en_C`  out  1 each  datapath pipeline register loads.
- `en_status`  out  1  status (Z/N/V) register load.
- `sel_A`  out  1  1 = ALU A input forced to zero (used by MOV-reg and MVN).
- `n_retired`  out  CNT_W  count of retired instructions.

## Operation
- Instruction classes, from the latched op pair:
  - MOVI: opcode 110, op 10.
  - MOVR: opcode 110, op 00.
  - ADD: opcode 101, op 00.
  - CMP: opcode 101, op 01.
  - AND: opcode 101, op 10.
  - MVN: opcode 101, op 11.
  - HALT: opcode 111, any op.
  - All other combinations are ILLEGAL.
- In S_WAIT with `start`=1: latch `opcode`/`ALU_op` and go to S_DECODE. `start` in any other state is ignored.
- Transitions:
  - S_DECODE → S_WR_IMM for MOVI; S_GET_B for MOVR and MVN; S_GET_A for ADD, CMP and AND; S_HALT for HALT; S_WAIT for ILLEGAL.
  - S_GET_A → S_GET_B.
  - S_GET_B → S_EXEC.
  - S_EXEC → S_WAIT for CMP; S_WR_REG otherwise.
  - S_WR_REG → S_WAIT.
  - S_WR_IMM → S_WAIT.
  - S_HALT → S_HALT until reset.
- Outputs are a function of state and latched op only. All unlisted strobes are 0, and `reg_sel`=00, `wb_sel`=00, `sel_A`=0.
  - S_GET_A: `reg_sel`=10, `en_A`=1.
  - S_GET_B: `reg_sel`=00, `en_B`=1.
  - S_EXEC: `sel_A`=1 for MOVR/MVN. `en_C`=1 for all classes except CMP. `en_status`=1 for CMP only.
  - S_WR_REG: `reg_sel`=01, `wb_sel`=00, `w_en`=1.
  - S_WR_IMM: `reg_sel`=10, `wb_sel`=10, `w_en`=1.
- `n_retired` increments by 1 on every transition into S_WAIT from S_WR_REG, S_WR_IMM, or S_EXEC (CMP).
  - It wraps from 2^CNT_W−1 to 0 with no flag.
  - ILLEGAL and HALT do not increment it.
- `w_en` and `en_status` are never high in the same cycle. `w_en` is high for exactly one cycle per MOVI/MOVR/ADD/AND/MVN.

## Timing
- Reset (`rst_n`=0, asynchronous): state is S_WAIT and the latched op is cleared. `waiting`=1, `halted`=0, every strobe is 0, `reg_sel`=00, `wb_sel`=00, `n_retired`=0.
- Reset asserted mid-instruction aborts it immediately. No further strobes are issued and the counter clears.
- Counting edge E as the edge that samples `start`, `waiting` is low for the following numbers of cycles:
  - MOVI: 2 (DECODE, WR_IMM).
  - MOVR, MVN: 4.
  - ADD, AND: 5.
  - CMP: 4.
  - ILLEGAL: 1.
- `waiting` returns high in the cycle after the last active state. A new `start` may be sampled on that cycle's edge, giving back-to-back issue with no bubble.
- `start` held high continuously issues a new instruction on each return to S_WAIT.
- `opcode`/`ALU_op` changing after edge E has no effect on the running instruction.
- From S_HALT, only `rst_n` exits.

## Test plan
- Reset: assert `rst_n`=0 mid-ADD, in S_GET_B. All outputs immediately take their reset values; after release `waiting`=1 and `n_retired`=0.
- MOVI (110/10) with `start` pulsed once: S_DECODE then S_WR_IMM with `reg_sel`=10, `wb_sel`=10, `w_en`=1 for one cycle. `waiting` is high again 2 cycles later and `n_retired`=1.
- ADD (101/00): sequence is `en_A`(`reg_sel`=10), then `en_B`(`reg_sel`=00), then `en_C`, then `w_en`(`reg_sel`=01). `en_status`=0 throughout. Changing `opcode` to 111 after edge E has no effect.
- CMP then MVN back-to-back with `start` held high:
  - CMP: `en_status`=1 in EXEC, `w_en` never high.
  - MVN: skips GET_A; `sel_A`=1 with `en_C`=1 in EXEC.
  - `n_retired`=2 at the end.
- ILLEGAL (000/00): one cycle in DECODE, no strobes, counter unchanged. HALT (111/xx): `halted`=1 and `waiting`=0 persist through 20 `start` pulses until `rst_n` is asserted.
- Wrap: with CNT_W=4, 17 MOVI instructions leave `n_retired`=1.

Source files
------------

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: handshake and strobe bundle between the fetch/decode
// side and the cpu_controller sequencing FSM.
//   master : fetch side; drives start/opcode/ALU_op, observes the rest.
//   slave  : controller; samples start/opcode/ALU_op, drives waiting,
//            halted, reg_sel, wb_sel, w_en, en_A/B/C, en_status, sel_A
//            and the retired-instruction count n_retired.
interface cpu_controller_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [2:0]       opcode;
  logic [1:0]       ALU_op;
  logic             waiting;
  logic             halted;
  logic [1:0]       reg_sel;
  logic [1:0]       wb_sel;
  logic             w_en;
  logic             en_A;
  logic             en_B;
  logic             en_C;
  logic             en_status;
  logic             sel_A;
  logic [CNT_W-1:0] n_retired;

  modport master (
    output start, opcode, ALU_op,
    input  waiting, halted, reg_sel, wb_sel, w_en,
           en_A, en_B, en_C, en_status, sel_A, n_retired
  );

  modport slave (
    input  start, opcode, ALU_op,
    output waiting, halted, reg_sel, wb_sel, w_en,
           en_A, en_B, en_C, en_status, sel_A, n_retired
  );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: Moore sequencing FSM for the 16-bit CPU datapath.
// Accepts an instruction on start while waiting, latches opcode/ALU_op,
// then walks the datapath strobes for MOVI, MOVR, ADD, CMP, AND, MVN and
// HALT. Counts retired instructions in a wrapping CNT_W-bit counter.
// Ports:
//   clk   : system clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : cpu_controller_if slave modport (handshake, strobes, counter).
module cpu_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_controller_if.slave  bus
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_GET_A  = 3'd2;
  localparam logic [2:0] S_GET_B  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WR_REG = 3'd5;
  localparam logic [2:0] S_WR_IMM = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  logic [2:0]       state_reg, state_next;
  logic [4:0]       op_reg;        // {opcode, ALU_op} captured at issue
  logic [CNT_W-1:0] cnt_reg;

  logic is_movi, is_movr, is_add, is_cmp, is_and, is_mvn, is_halt;
  logic retire;

  // Instruction class from the latched pair only, so later changes on the
  // decoder inputs cannot disturb a running instruction.
  assign is_movi = (op_reg == 5'b110_10);
  assign is_movr = (op_reg == 5'b110_00);
  assign is_add  = (op_reg == 5'b101_00);
  assign is_cmp  = (op_reg == 5'b101_01);
  assign is_and  = (op_reg == 5'b101_10);
  assign is_mvn  = (op_reg == 5'b101_11);
  assign is_halt = (op_reg[4:2] == 3'b111);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT:   if (bus.start) state_next = S_DECODE;
      S_DECODE: begin
        if (is_movi)                      state_next = S_WR_IMM;
        else if (is_movr || is_mvn)       state_next = S_GET_B;
        else if (is_add || is_cmp || is_and) state_next = S_GET_A;
        else if (is_halt)                 state_next = S_HALT;
        else                              state_next = S_WAIT;  // illegal
      end
      S_GET_A:  state_next = S_GET_B;
      S_GET_B:  state_next = S_EXEC;
      S_EXEC:   state_next = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_REG: state_next = S_WAIT;
      S_WR_IMM: state_next = S_WAIT;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_WAIT;
    endcase
  end

  // Every state listed here always returns to S_WAIT next, so this marks
  // exactly the instructions that complete (illegal/halt never get here).
  assign retire = (state_reg == S_WR_REG) || (state_reg == S_WR_IMM) ||
                  ((state_reg == S_EXEC) && is_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_WAIT;
      op_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_WAIT && bus.start)
        op_reg <= {bus.opcode, bus.ALU_op};
      if (retire)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    bus.waiting   = (state_reg == S_WAIT);
    bus.halted    = (state_reg == S_HALT);
    bus.reg_sel   = 2'b00;
    bus.wb_sel    = 2'b00;
    bus.w_en      = 1'b0;
    bus.en_A      = 1'b0;
    bus.en_B      = 1'b0;
    bus.en_C      = 1'b0;
    bus.en_status = 1'b0;
    bus.sel_A     = 1'b0;
    case (state_reg)
      S_GET_A: begin
        bus.reg_sel = 2'b10;
        bus.en_A    = 1'b1;
      end
      S_GET_B: bus.en_B = 1'b1;
      S_EXEC: begin
        bus.sel_A     = is_movr || is_mvn;   // A forced to zero
        bus.en_C      = !is_cmp;
        bus.en_status = is_cmp;
      end
      S_WR_REG: begin
        bus.reg_sel = 2'b01;
        bus.w_en    = 1'b1;
      end
      S_WR_IMM: begin
        bus.reg_sel = 2'b10;
        bus.wb_sel  = 2'b10;
        bus.w_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.n_retired = cnt_reg;

endmodule
